// File: rtl/and21nor_bist.sv
`default_nettype none
// ============================================================================
//  Module      : and21nor_bist
//  Description : Built-in self-test driver/checker for one and21nor cell,
//                nq = ~((i0 & i1) | i2). Walks all 8 input vectors LOOPS
//                times, compares the returned nq against the golden function
//                LAT cycles later, and reports pass/fail, a saturating error
//                count and the first failing vector.
//  Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Parameters
//    LAT    cycles from driving a vector to sampling nq_in (>=1)
//    LOOPS  number of full passes over the 8 vectors (>=1)
//    ERR_W  width of err_cnt
//  Ports
//    ck             in   clock, all registers update on its rising edge
//    rst            in   synchronous active-high reset
//    start          in   one-cycle test request, honoured in IDLE or DONE
//    nq_in          in   nq output of the cell under test
//    i0,i1,i2       out  registered stimulus, vector v = {i2,i1,i0}
//    busy           out  test in progress
//    done           out  test finished, holds until next start or rst
//    pass           out  done and no mismatches
//    err_cnt        out  mismatch count, saturates at all-ones
//    first_fail_vec out  v of the first mismatch (valid when err_cnt != 0)
//    sig            out  16-bit response signature (AND21NOR_BIST_MISR_EN only)
//  Configuration macro
//    AND21NOR_BIST_MISR_EN : adds the sig port and the signature register
// ============================================================================
module and21nor_bist #(
   parameter int LAT   = 1,
   parameter int LOOPS = 1,
   parameter int ERR_W = 8
) (
   input  logic             ck,
   input  logic             rst,
   input  logic             start,
   input  logic             nq_in,
   output logic             i0,
   output logic             i1,
   output logic             i2,
   output logic             busy,
   output logic             done,
   output logic             pass,
   output logic [ERR_W-1:0] err_cnt,
   output logic [2:0]       first_fail_vec
`ifdef AND21NOR_BIST_MISR_EN
   ,
   output logic [15:0]      sig
`endif
);

   localparam int c_LW = (LOOPS > 1) ? $clog2(LOOPS) : 1;
   localparam int c_DW = (LAT > 1) ? $clog2(LAT) : 1;
   localparam logic [c_LW-1:0]  c_LAST_LOOP  = c_LW'(LOOPS - 1);
   localparam logic [c_DW-1:0]  c_LAST_DRAIN = c_DW'(LAT - 1);
   localparam logic [ERR_W-1:0] c_ERR_ONE    = ERR_W'(1);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_RUN   = 2'd1,
      S_DRAIN = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   state_t          r_state;
   logic [2:0]      r_vcnt;
   logic [c_LW-1:0] r_lcnt;
   logic [c_DW-1:0] r_dcnt;

   // Delay line aligning each driven vector with the cell response.
   logic            r_dl_vld [LAT];
   logic [2:0]      r_dl_vec [LAT];
   logic            r_dl_exp [LAT];

   logic            w_out_vld;
   logic [2:0]      w_out_vec;
   logic            w_out_exp;
   logic            w_mismatch;

   assign w_out_vld  = r_dl_vld[LAT-1];
   assign w_out_vec  = r_dl_vec[LAT-1];
   assign w_out_exp  = r_dl_exp[LAT-1];
   assign w_mismatch = w_out_vld && (nq_in != w_out_exp);

   assign pass = done && (err_cnt == '0);

   always_ff @(posedge ck) begin
      if (rst) begin
         r_state        <= S_IDLE;
         r_vcnt         <= '0;
         r_lcnt         <= '0;
         r_dcnt         <= '0;
         i0             <= 1'b0;
         i1             <= 1'b0;
         i2             <= 1'b0;
         busy           <= 1'b0;
         done           <= 1'b0;
         err_cnt        <= '0;
         first_fail_vec <= '0;
         for (int k = 0; k < LAT; k++) begin
            r_dl_vld[k] <= 1'b0;
            r_dl_vec[k] <= '0;
            r_dl_exp[k] <= 1'b0;
         end
`ifdef AND21NOR_BIST_MISR_EN
         sig            <= 16'hFFFF;
`endif
      end else begin
         // Status flags trail the state by one cycle, so busy covers exactly
         // the RUN+DRAIN span and done rises one edge after the final compare.
         busy <= (r_state == S_RUN) || (r_state == S_DRAIN);
         done <= (r_state == S_DONE) && !start;

         r_dl_vld[0] <= 1'b0;
         for (int k = LAT - 1; k > 0; k--) begin
            r_dl_vld[k] <= r_dl_vld[k-1];
            r_dl_vec[k] <= r_dl_vec[k-1];
            r_dl_exp[k] <= r_dl_exp[k-1];
         end

         if (w_mismatch) begin
            if (err_cnt != '1)
               err_cnt <= err_cnt + c_ERR_ONE;
            if (err_cnt == '0)
               first_fail_vec <= w_out_vec;
         end

`ifdef AND21NOR_BIST_MISR_EN
         if (w_out_vld)
            sig <= {sig[14:0], sig[15] ^ sig[13] ^ sig[12] ^ sig[10] ^ nq_in};
`endif

         case (r_state)
            S_IDLE, S_DONE: begin
               {i2, i1, i0} <= 3'd0;
               if (start) begin
                  r_state        <= S_RUN;
                  r_vcnt         <= '0;
                  r_lcnt         <= '0;
                  err_cnt        <= '0;
                  first_fail_vec <= '0;
`ifdef AND21NOR_BIST_MISR_EN
                  sig            <= 16'hFFFF;
`endif
               end
            end
            S_RUN: begin
               {i2, i1, i0} <= r_vcnt;
               r_dl_vld[0]  <= 1'b1;
               r_dl_vec[0]  <= r_vcnt;
               r_dl_exp[0]  <= ~((r_vcnt[0] & r_vcnt[1]) | r_vcnt[2]);
               r_vcnt       <= r_vcnt + 3'd1;
               if (r_vcnt == 3'd7) begin
                  if (r_lcnt == c_LAST_LOOP) begin
                     r_state <= S_DRAIN;
                     r_dcnt  <= '0;
                  end else begin
                     r_lcnt <= r_lcnt + c_LW'(1);
                  end
               end
            end
            S_DRAIN: begin
               {i2, i1, i0} <= 3'd0;
               // Leaves on the edge that performs the final compare.
               if (r_dcnt == c_LAST_DRAIN)
                  r_state <= S_DONE;
               else
                  r_dcnt <= r_dcnt + c_DW'(1);
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_and21nor_bist.sv
`default_nettype none
// ============================================================================
//  Module      : tb_and21nor_bist
//  Description : Self-checking bench for and21nor_bist. Three instances:
//                A (LAT=1, LOOPS=1, ERR_W=8), B (LAT=1, LOOPS=64, ERR_W=8),
//                C (LAT=3, LOOPS=2, ERR_W=3). Each drives a modelled cell whose
//                output is good, stuck-at-1, stuck-at-0 or flipped on a mask.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_and21nor_bist;

   logic ck = 1'b0;
   always #5 ck = ~ck;

   logic       rst;
   logic [2:0] start_v;
   logic [2:0] busy_v, done_v, pass_v;
   logic [2:0] ia, ib, ic;
   logic [7:0] err_a, err_b;
   logic [2:0] err_c;
   logic [2:0] ffv_a, ffv_b, ffv_c;
   logic       nq_a, nq_b, nq_c, nq_c_d1, nq_c_d2;
   logic [1:0] mode_a, mode_b, mode_c;
   logic [7:0] mask_a, mask_b, mask_c;
`ifdef AND21NOR_BIST_MISR_EN
   logic [15:0] sig_a, sig_b, sig_c;
`endif

   int checks = 0;
   int passed = 0;

   function automatic logic golden(input logic [2:0] v);
      return ~((v[0] & v[1]) | v[2]);
   endfunction

   // mode 0: golden xor mask[v], mode 1: stuck-at-1, mode 2: stuck-at-0
   function automatic logic cell_out(input logic [1:0] mode, input logic [7:0] mask,
                                     input logic [2:0] v);
      if (mode == 2'd1) return 1'b1;
      if (mode == 2'd2) return 1'b0;
      return golden(v) ^ mask[v];
   endfunction

   function automatic int ref_per_loop(input logic [1:0] mode, input logic [7:0] mask);
      int c = 0;
      for (int v = 0; v < 8; v++)
         if (cell_out(mode, mask, 3'(v)) != golden(3'(v))) c++;
      return c;
   endfunction

   function automatic logic [2:0] ref_first(input logic [1:0] mode, input logic [7:0] mask);
      for (int v = 0; v < 8; v++)
         if (cell_out(mode, mask, 3'(v)) != golden(3'(v))) return 3'(v);
      return 3'd0;
   endfunction

`ifdef AND21NOR_BIST_MISR_EN
   function automatic logic [16-1:0] ref_sig(input logic [1:0] mode, input logic [7:0] mask,
                                             input int loops);
      logic [15:0] s = 16'hFFFF;
      for (int l = 0; l < loops; l++)
         for (int v = 0; v < 8; v++)
            s = {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10] ^ cell_out(mode, mask, 3'(v))};
      return s;
   endfunction
`endif

   assign nq_a = cell_out(mode_a, mask_a, ia);
   assign nq_b = cell_out(mode_b, mask_b, ib);
   // Instance C sees the cell through two extra pipeline stages (LAT=3).
   always @(posedge ck) begin
      nq_c_d1 <= cell_out(mode_c, mask_c, ic);
      nq_c_d2 <= nq_c_d1;
   end
   assign nq_c = nq_c_d2;

   and21nor_bist #(.LAT(1), .LOOPS(1), .ERR_W(8)) u_dut_a (
      .ck(ck), .rst(rst), .start(start_v[0]), .nq_in(nq_a),
      .i0(ia[0]), .i1(ia[1]), .i2(ia[2]),
      .busy(busy_v[0]), .done(done_v[0]), .pass(pass_v[0]),
      .err_cnt(err_a), .first_fail_vec(ffv_a)
`ifdef AND21NOR_BIST_MISR_EN
      , .sig(sig_a)
`endif
   );

   and21nor_bist #(.LAT(1), .LOOPS(64), .ERR_W(8)) u_dut_b (
      .ck(ck), .rst(rst), .start(start_v[1]), .nq_in(nq_b),
      .i0(ib[0]), .i1(ib[1]), .i2(ib[2]),
      .busy(busy_v[1]), .done(done_v[1]), .pass(pass_v[1]),
      .err_cnt(err_b), .first_fail_vec(ffv_b)
`ifdef AND21NOR_BIST_MISR_EN
      , .sig(sig_b)
`endif
   );

   and21nor_bist #(.LAT(3), .LOOPS(2), .ERR_W(3)) u_dut_c (
      .ck(ck), .rst(rst), .start(start_v[2]), .nq_in(nq_c),
      .i0(ic[0]), .i1(ic[1]), .i2(ic[2]),
      .busy(busy_v[2]), .done(done_v[2]), .pass(pass_v[2]),
      .err_cnt(err_c), .first_fail_vec(ffv_c)
`ifdef AND21NOR_BIST_MISR_EN
      , .sig(sig_c)
`endif
   );

   // Pulses start on instance d and waits for done. n = edges after the start
   // edge until done is seen; bc = sampled cycles with busy high. A start
   // pulse is re-issued mid-run when n == mid (use -1 for none).
   task automatic run(input int d, input int mid, output int n, output int bc);
      start_v[d] = 1'b1;
      @(negedge ck);
      start_v[d] = 1'b0;
      n  = 0;
      bc = 0;
      while (!done_v[d] && n < 2000) begin
         if (busy_v[d]) bc++;
         start_v[d] = (n == mid);
         @(negedge ck);
         n++;
      end
      start_v[d] = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (2) @(negedge ck);
      rst = 1'b0;
      checks++; if ({ia, busy_v[0], done_v[0], pass_v[0]} !== 6'd0)
         $display("FAIL reset_outputs: got %b want 000000", {ia, busy_v[0], done_v[0], pass_v[0]}); else passed++;
      checks++; if (err_a !== 8'd0) $display("FAIL reset_err_cnt: got %0d want 0", err_a); else passed++;
      checks++; if (ffv_a !== 3'd0) $display("FAIL reset_first_fail: got %0d want 0", ffv_a); else passed++;
      checks++; if ({ic, busy_v[2], done_v[2], err_c} !== 9'd0)
         $display("FAIL reset_inst_c: got %b want 0", {ic, busy_v[2], done_v[2], err_c}); else passed++;
`ifdef AND21NOR_BIST_MISR_EN
      checks++; if (sig_a !== 16'hFFFF) $display("FAIL reset_sig: got %h want ffff", sig_a); else passed++;
`endif
   endtask

   task automatic test_good_cell();
      int n, bc;
      mode_a = 2'd0; mask_a = 8'd0;
      run(0, -1, n, bc);
      checks++; if (n !== 10) $display("FAIL good_done_edge: got %0d want 10", n); else passed++;
      checks++; if (bc !== 9) $display("FAIL good_busy_cycles: got %0d want 9", bc); else passed++;
      checks++; if (pass_v[0] !== 1'b1) $display("FAIL good_pass: got %b want 1", pass_v[0]); else passed++;
      checks++; if (err_a !== 8'd0) $display("FAIL good_err_cnt: got %0d want 0", err_a); else passed++;
      repeat (5) @(negedge ck);
      checks++; if ({done_v[0], pass_v[0], busy_v[0], ia} !== 6'b110000)
         $display("FAIL good_done_hold: got %b want 110000", {done_v[0], pass_v[0], busy_v[0], ia}); else passed++;
   endtask

   task automatic test_stuck();
      int n, bc;
      mode_a = 2'd1;
      run(0, -1, n, bc);
      checks++; if (err_a !== 8'd5) $display("FAIL stuck1_err_cnt: got %0d want 5", err_a); else passed++;
      checks++; if (ffv_a !== 3'd3) $display("FAIL stuck1_first_fail: got %0d want 3", ffv_a); else passed++;
      checks++; if ({done_v[0], pass_v[0]} !== 2'b10) $display("FAIL stuck1_pass: got %b want 10", {done_v[0], pass_v[0]}); else passed++;
      mode_a = 2'd2;
      run(0, -1, n, bc);
      checks++; if (err_a !== 8'd3) $display("FAIL stuck0_err_cnt: got %0d want 3", err_a); else passed++;
      checks++; if (ffv_a !== 3'd0) $display("FAIL stuck0_first_fail: got %0d want 0", ffv_a); else passed++;
      checks++; if (pass_v[0] !== 1'b0) $display("FAIL stuck0_pass: got %b want 0", pass_v[0]); else passed++;
   endtask

   task automatic test_saturate();
      int n, bc;
      mode_b = 2'd1; mask_b = 8'd0;
      run(1, -1, n, bc);
      checks++; if (n !== 8*64+2) $display("FAIL sat_done_edge: got %0d want %0d", n, 8*64+2); else passed++;
      checks++; if (bc !== 8*64+1) $display("FAIL sat_busy_cycles: got %0d want %0d", bc, 8*64+1); else passed++;
      checks++; if (err_b !== 8'd255) $display("FAIL sat_err_cnt: got %0d want 255", err_b); else passed++;
      checks++; if (ffv_b !== 3'd3) $display("FAIL sat_first_fail: got %0d want 3", ffv_b); else passed++;
   endtask

   task automatic test_reset_midrun();
      int n, bc, t;
      mode_a = 2'd1;
      start_v[0] = 1'b1;
      @(negedge ck);
      start_v[0] = 1'b0;
      t = 0;
      while (!(busy_v[0] && ia == 3'd4) && t < 50) begin
         @(negedge ck);
         t++;
      end
      checks++; if (t >= 50) $display("FAIL midrun_reach_v4: got timeout want v=4"); else passed++;
      rst = 1'b1;
      @(negedge ck);
      rst = 1'b0;
      checks++; if ({ia, busy_v[0], done_v[0], pass_v[0]} !== 6'd0)
         $display("FAIL midrun_reset_outputs: got %b want 000000", {ia, busy_v[0], done_v[0], pass_v[0]}); else passed++;
      checks++; if ({err_a, ffv_a} !== 11'd0) $display("FAIL midrun_reset_results: got err=%0d ffv=%0d want 0 0", err_a, ffv_a); else passed++;
      repeat (3) @(negedge ck);
      checks++; if ({busy_v[0], ia} !== 4'd0) $display("FAIL midrun_stays_idle: got %b want 0000", {busy_v[0], ia}); else passed++;
      mode_a = 2'd0; mask_a = 8'd0;
      run(0, 3, n, bc);
      checks++; if (n !== 10) $display("FAIL midrun_start_ignored: got %0d want 10", n); else passed++;
      checks++; if ({pass_v[0], err_a} !== 9'h100) $display("FAIL midrun_clean_pass: got pass=%b err=%0d want 1 0", pass_v[0], err_a); else passed++;
   endtask

   task automatic test_random_a();
      int n, bc, e;
      for (int it = 0; it < 8; it++) begin
         mode_a = 2'($urandom_range(0, 2));
         mask_a = 8'($urandom);
         e = ref_per_loop(mode_a, mask_a);
         run(0, -1, n, bc);
         checks++; if (n !== 10) $display("FAIL rand_a_done_edge[%0d]: got %0d want 10", it, n); else passed++;
         checks++; if (err_a !== 8'(e)) $display("FAIL rand_a_err[%0d]: got %0d want %0d", it, err_a, e); else passed++;
         checks++; if (pass_v[0] !== (e == 0)) $display("FAIL rand_a_pass[%0d]: got %b want %b", it, pass_v[0], e == 0); else passed++;
         if (e != 0) begin
            checks++; if (ffv_a !== ref_first(mode_a, mask_a))
               $display("FAIL rand_a_first[%0d]: got %0d want %0d", it, ffv_a, ref_first(mode_a, mask_a)); else passed++;
         end
`ifdef AND21NOR_BIST_MISR_EN
         checks++; if (sig_a !== ref_sig(mode_a, mask_a, 1))
            $display("FAIL rand_a_sig[%0d]: got %h want %h", it, sig_a, ref_sig(mode_a, mask_a, 1)); else passed++;
`endif
      end
   endtask

   task automatic test_random_lat3();
      int n, bc, e;
      for (int it = 0; it < 8; it++) begin
         mode_c = 2'($urandom_range(0, 2));
         mask_c = (it == 0) ? 8'd0 : 8'($urandom);
         e = 2 * ref_per_loop(mode_c, mask_c);
         if (e > 7) e = 7;
         run(2, -1, n, bc);
         checks++; if (n !== 20) $display("FAIL lat3_done_edge[%0d]: got %0d want 20", it, n); else passed++;
         checks++; if (bc !== 19) $display("FAIL lat3_busy_cycles[%0d]: got %0d want 19", it, bc); else passed++;
         checks++; if (err_c !== 3'(e)) $display("FAIL lat3_err[%0d]: got %0d want %0d", it, err_c, e); else passed++;
         checks++; if (pass_v[2] !== (e == 0)) $display("FAIL lat3_pass[%0d]: got %b want %b", it, pass_v[2], e == 0); else passed++;
         if (e != 0) begin
            checks++; if (ffv_c !== ref_first(mode_c, mask_c))
               $display("FAIL lat3_first[%0d]: got %0d want %0d", it, ffv_c, ref_first(mode_c, mask_c)); else passed++;
         end
      end
   endtask

`ifdef AND21NOR_BIST_MISR_EN
   task automatic test_misr();
      int n, bc;
      mode_a = 2'd0; mask_a = 8'd0;
      run(0, -1, n, bc);
      checks++; if (sig_a !== 16'hFFE0) $display("FAIL misr_good: got %h want ffe0", sig_a); else passed++;
      repeat (4) @(negedge ck);
      checks++; if (sig_a !== 16'hFFE0) $display("FAIL misr_hold: got %h want ffe0", sig_a); else passed++;
      mode_a = 2'd1;
      run(0, -1, n, bc);
      checks++; if (sig_a === 16'hFFE0) $display("FAIL misr_stuck1_differs: got %h want not ffe0", sig_a); else passed++;
      checks++; if (sig_a !== ref_sig(2'd1, 8'd0, 1))
         $display("FAIL misr_stuck1_value: got %h want %h", sig_a, ref_sig(2'd1, 8'd0, 1)); else passed++;
   endtask
`endif

   initial begin
      rst     = 1'b1;
      start_v = 3'd0;
      mode_a  = 2'd0; mask_a = 8'd0;
      mode_b  = 2'd0; mask_b = 8'd0;
      mode_c  = 2'd0; mask_c = 8'd0;
      @(negedge ck);
      test_reset();
      test_good_cell();
      test_stuck();
      test_saturate();
      test_reset_midrun();
      test_random_a();
      test_random_lat3();
`ifdef AND21NOR_BIST_MISR_EN
      test_misr();
`endif
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
`default_nettype wire
